// File: rtl/anc_pkg.sv
// anc_pkg: shared defaults, FSM encoding and round/saturate helper for the filtered-x FIR
package anc_pkg;
  localparam int TAPS_DEF  = 128;
  localparam int DW_DEF    = 16;
  localparam int ACC_W_DEF = 40;
  localparam int SHIFT_DEF = 15;
  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] a, input int sh, input int dw);
    logic signed [63:0] r, hi, lo;
    r  = (a + (64'sd1 <<< (sh - 1))) >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/anc_sp_ring_ram.sv
// anc_sp_ring_ram: simple dual-port RAM with one-cycle registered read
module anc_sp_ring_ram #(
  parameter int DEPTH = 128,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/anc_sec_path_fir.sv
// anc_sec_path_fir: serial-MAC secondary-path FIR producing filtered reference x'(n)
module anc_sec_path_fir
  import anc_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           xn_i,
  input  logic                    xn_valid,
  input  logic                    coef_wr_en,
  input  logic [$clog2(TAPS)-1:0] coef_wr_addr,
  input  logic [DW-1:0]           coef_wr_data,
  output logic [DW-1:0]           fxn_o,
  output logic                    fxn_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    coef_err
);
  localparam int AW = $clog2(TAPS);
  state_t                   state;
  logic [AW-1:0]            wr_ptr, base, k, pend_addr;
  logic [AW:0]              fill_cnt;
  logic                     d, v1, pend_v;
  logic [DW-1:0]            pend_data, x_q, h_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [2*DW-1:0]   prod;
  logic                     idle, accept, coef_direct, coef_we;
  assign idle        = state == IDLE;
  assign busy        = !idle;
  assign accept      = idle && xn_valid;
  assign coef_direct = idle && coef_wr_en && !xn_valid;
  assign coef_we     = coef_direct || (state == OUT && pend_v);
  assign prod        = $signed(x_q) * $signed(h_q);
  anc_sp_ring_ram #(.DEPTH(TAPS), .W(DW)) u_ring (
    .clk(clk), .we(accept), .waddr(wr_ptr), .wdata(xn_i),
    .raddr(base - k), .rdata(x_q)
  );
  anc_sp_ring_ram #(.DEPTH(TAPS), .W(DW)) u_coef (
    .clk(clk), .we(coef_we),
    .waddr(coef_direct ? coef_wr_addr : pend_addr),
    .wdata(coef_direct ? coef_wr_data : pend_data),
    .raddr(k), .rdata(h_q)
  );
  // FSM, history-masked MAC pipeline, deferred same-cycle coef write, sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      base      <= '0;
      k         <= '0;
      fill_cnt  <= '0;
      d         <= 1'b0;
      v1        <= 1'b0;
      acc       <= '0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      fxn_o     <= '0;
      fxn_valid <= 1'b0;
      overrun   <= 1'b0;
      coef_err  <= 1'b0;
    end else begin
      fxn_valid <= 1'b0;
      v1        <= state == MAC && {1'b0, k} < fill_cnt;
      if (v1) acc <= acc + ACC_W'(prod);
      if (xn_valid && !idle) overrun <= 1'b1;
      if (coef_wr_en && !idle) coef_err <= 1'b1;
      case (state)
        IDLE: if (xn_valid) begin
          base      <= wr_ptr;
          wr_ptr    <= wr_ptr + 1'b1;
          fill_cnt  <= fill_cnt == (AW+1)'(TAPS) ? fill_cnt : fill_cnt + 1'b1;
          acc       <= '0;
          k         <= '0;
          pend_v    <= coef_wr_en;
          pend_addr <= coef_wr_addr;
          pend_data <= coef_wr_data;
          state     <= MAC;
        end
        MAC: begin
          k <= k + 1'b1;
          if (k == AW'(TAPS - 1)) begin
            d     <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          d <= 1'b1;
          if (d) begin
            fxn_o     <= DW'(sat_round(64'(acc), SHIFT, DW));
            fxn_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          pend_v <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_anc_sec_path_fir.sv
// tb_anc_sec_path_fir: directed self-checking bench for the filtered-x FIR
module tb_anc_sec_path_fir;
  localparam int TAPS = 128;
  localparam int LIM  = TAPS + 20;
  logic        clk = 0, rst = 1, xn_valid = 0, coef_wr_en = 0;
  logic [15:0] xn_i = '0, coef_wr_data = '0, fxn_o;
  logic [6:0]  coef_wr_addr = '0;
  logic        fxn_valid, busy, overrun, coef_err;
  logic        busy_out, busy_after;
  logic [15:0] y;
  int          lat, checks = 0, errors = 0;
  anc_sec_path_fir dut (
    .clk(clk), .rst(rst), .xn_i(xn_i), .xn_valid(xn_valid),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .fxn_o(fxn_o), .fxn_valid(fxn_valid), .busy(busy), .overrun(overrun), .coef_err(coef_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int a, input logic [15:0] v);
    coef_wr_en = 1; coef_wr_addr = 7'(a); coef_wr_data = v;
    tick;
    coef_wr_en = 0;
  endtask
  task automatic load_all(input logic [15:0] v);
    for (int i = 0; i < TAPS; i++) wr(i, v);
  endtask
  task automatic pulse_rst;
    rst = 1;
    tick;
    rst = 0;
  endtask
  // kind: 0 none, 1 extra xn at lat, 2 coef write at lat, 3 rst at lat, 4 coef write with the sample
  task automatic send(input logic [15:0] x, input int kind, input int at);
    xn_i = x; xn_valid = 1;
    if (kind == 4) coef_wr_en = 1;
    tick;
    xn_valid = 0; coef_wr_en = 0; lat = 1;
    while (fxn_valid !== 1'b1 && lat < LIM) begin
      if (lat == at && kind == 1) begin xn_valid = 1; xn_i = 16'd7777; end
      if (lat == at && kind == 2) coef_wr_en = 1;
      if (lat == at && kind == 3) rst = 1;
      tick;
      xn_valid = 0; coef_wr_en = 0; rst = 0;
      lat++;
    end
    y = fxn_o;
    busy_out = busy;
    if (kind != 3) chk("latency", lat, TAPS + 3);
    if (fxn_valid === 1'b1) tick;
    busy_after = busy;
  endtask
  initial begin
    tick; tick;
    rst = 0;
    chk("rst_fxn_o", fxn_o, 0);
    chk("rst_fxn_valid", fxn_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_coef_err", coef_err, 0);
    load_all(16'h0000);
    wr(0, 16'h4000);
    send(16'd1000, 0, 0);
    chk("t1_fxn", y, 500);
    chk("t1_busy_out", busy_out, 1);
    chk("t1_busy_after", busy_after, 0);
    pulse_rst;
    load_all(16'h0100);
    for (int j = 0; j < 129; j++) begin
      send(j == 0 ? 16'h7FFF : 16'h0000, 0, 0);
      chk(j < 128 ? "t2_impulse" : "t2_wrap", y, j < 128 ? 16'h0100 : 16'h0000);
    end
    load_all(16'h7FFF);
    for (int j = 0; j < 130; j++) begin
      send(16'h7FFF, 0, 0);
      if (j == 0) chk("t3_first", y, 16'h7FFE);
    end
    chk("t3_sat_pos", y, 16'h7FFF);
    for (int j = 0; j < 130; j++) send(16'h8000, 0, 0);
    chk("t3_sat_neg", y, 16'h8000);
    pulse_rst;
    load_all(16'h0000);
    wr(0, 16'h4000);
    wr(1, 16'h2000);
    send(16'd1000, 0, 0);
    chk("t4_first", y, 500);
    chk("t4_overrun_clear", overrun, 0);
    send(16'd2000, 1, 10);
    chk("t4_collide", y, 1250);
    chk("t4_overrun", overrun, 1);
    send(16'd400, 0, 0);
    chk("t4_after", y, 700);
    coef_wr_addr = 7'd0; coef_wr_data = 16'h2000;
    send(16'd1000, 2, 20);
    chk("t5_coef_busy", y, 600);
    chk("t5_coef_err", coef_err, 1);
    wr(0, 16'h2000);
    send(16'd1000, 0, 0);
    chk("t5_coef_idle", y, 500);
    coef_wr_addr = 7'd0; coef_wr_data = 16'h0000;
    send(16'd2000, 4, 0);
    chk("t5_same_cycle_old", y, 750);
    send(16'd0, 0, 0);
    chk("t5_same_cycle_new", y, 500);
    send(16'd1000, 3, 61);
    chk("t6_no_valid", lat, LIM);
    chk("t6_busy", busy, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_coef_err", coef_err, 0);
    wr(0, 16'h4000);
    wr(1, 16'h4000);
    send(16'd1000, 0, 0);
    chk("t6_masked", y, 500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
